// File: rtl/xor_vector_sequencer.sv
// Steps a 3-input gate through all eight input vectors, holds each for a
// programmable settle time, samples the gate output and grades it against EXPECT.
module xor_vector_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECT        = 8'h96
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       Output,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SC_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] vec;
    logic [2:0] vec_next;
    logic [3:0] sc;
    logic [3:0] sc_next;
    logic       accept;
    logic       sample_en;
    logic       finish;
    logic       sample_miss;

    // Handshake: start is a level request honoured only in IDLE when abort is
    // low; abort is honoured in every other state and wins over any sample.

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            vec   <= 3'd0;
            sc    <= 4'd0;
        end else begin
            state <= state_next;
            vec   <= vec_next;
            sc    <= sc_next;
        end
    end

    always_comb begin
        state_next = state;
        vec_next   = vec;
        sc_next    = sc;
        accept     = 1'b0;
        sample_en  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_SETTLE;
                    vec_next   = 3'd0;
                    sc_next    = SC_LOAD;
                    accept     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (sc == 4'd0) begin
                    state_next = S_SAMPLE;
                end else begin
                    sc_next = sc - 4'd1;
                end
            end
            S_SAMPLE: begin
                sample_en = 1'b1;
                if (vec == 3'd7) begin
                    state_next = S_DONE;
                end else begin
                    vec_next   = vec + 3'd1;
                    sc_next    = SC_LOAD;
                    state_next = S_SETTLE;
                end
            end
            S_DONE: begin
                finish     = 1'b1;
                state_next = S_IDLE;
                vec_next   = 3'd0;
            end
            default: begin
                state_next = S_IDLE;
                vec_next   = 3'd0;
            end
        endcase

        // Abort overrides whatever the active state decided above.
        if (state != S_IDLE && abort) begin
            state_next = S_IDLE;
            vec_next   = 3'd0;
            sc_next    = 4'd0;
            sample_en  = 1'b0;
            finish     = 1'b0;
        end
    end

    assign sample_miss = (Output != EXPECT[vec]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= 8'h00;
            mismatch_count <= 4'd0;
            first_fail     <= 3'd0;
            fail_valid     <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            if (accept) begin
                pass           <= 1'b0;
                captured       <= 8'h00;
                mismatch_count <= 4'd0;
                first_fail     <= 3'd0;
                fail_valid     <= 1'b0;
            end
            if (sample_en) begin
                captured[vec] <= Output;
                if (sample_miss) begin
                    mismatch_count <= mismatch_count + 4'd1;
                    if (!fail_valid) begin
                        first_fail <= vec;
                        fail_valid <= 1'b1;
                    end
                end
            end
            // Count already includes the final sample by the time DONE is left.
            if (finish) begin
                pass <= (mismatch_count == 4'd0);
            end
        end
    end

    assign i1 = vec[0];
    assign i2 = vec[1];
    assign i3 = vec[2];

endmodule
